// File: rtl/imem_program_loader.sv
// imem_program_loader: packs a byte stream into 20-bit words and writes them to instruction memory, holding the CPU in reset until done.
//   Stream: LEN_LO, LEN_HI (word count N), then N x {b0, b1, b2}; word = {b2[3:0], b1, b0}.
//   Ports: clk, rst_n (async active-low); start_i pulse begins a session;
//          in_data_i/in_valid_i/in_ready_o byte handshake; imem_we_o/imem_addr_o/imem_wdata_o write port;
//          cpu_hold_o keeps the CPU in reset; done_o program loaded; error_o session aborted.
//   Optional macro LOADER_CHECKSUM_EN: one trailing byte must equal the XOR of all payload bytes.
module imem_program_loader #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [7:0]         in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               imem_we_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [INSTR_W-1:0] imem_wdata_o,
  output logic               cpu_hold_o,
  output logic               done_o,
  output logic               error_o
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;
  // capacity as a 17-bit value so N == 2^ADDR_W is still accepted
  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);
  state_t              state_q, state_d;
  logic                rdy_q, rdy_d, we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;
  logic [15:0]         len_q, len_d, buf_q, buf_d;
  logic [16:0]         cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                xfer, go_done, go_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif
  assign xfer = in_valid_i & rdy_q;
  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    we_d    = 1'b0;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    go_done = 1'b0;
    go_err  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_LEN0: if (xfer) begin
        len_d[7:0] = in_data_i;
        state_d    = S_LEN1;
      end
      S_LEN1: if (xfer) begin
        len_d   = {in_data_i, len_q[7:0]};
        go_done = len_d == 16'd0;
        go_err  = len_d != 16'd0 && {1'b0, len_d} > CAP;
        state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
        csum_d = csum_q ^ in_data_i;
`endif
        idx_d = idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
        if (idx_q == 2'd0) buf_d[7:0] = in_data_i;
        if (idx_q == 2'd1) buf_d[15:8] = in_data_i;
        if (idx_q == 2'd2) begin
          // a nonzero upper nibble in b2 is malformed: abort without writing
          go_err = in_data_i[7:4] != 4'd0;
          if (!go_err) begin
            wdata_d = INSTR_W'({in_data_i[3:0], buf_q});
            we_d    = 1'b1;
            rdy_d   = 1'b0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 17'd1;
        rdy_d  = 1'b1;
        state_d = S_DATA;
        if (cnt_d == {1'b0, len_q}) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          go_done = 1'b1;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (xfer) begin
        go_done = in_data_i == csum_q;
        go_err  = in_data_i != csum_q;
      end
`endif
      default: ;
    endcase
    if (go_done) begin
      state_d = S_DONE;
      rdy_d   = 1'b0;
      done_d  = 1'b1;
      hold_d  = 1'b0;
    end
    if (go_err) begin
      state_d = S_ERR;
      rdy_d   = 1'b0;
      err_d   = 1'b1;
    end
    // start is honoured only outside an active session
    if (start_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR)) begin
      state_d = S_LEN0;
      rdy_d   = 1'b1;
      hold_d  = 1'b1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      addr_d  = '0;
      cnt_d   = '0;
      idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  assign in_ready_o   = rdy_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign error_o      = err_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: table-driven and sequence checks of imem_program_loader (ADDR_W=8).
module tb_imem_program_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, in_valid_i = 1'b0;
  logic [7:0]  in_data_i = '0;
  logic        in_ready_o, imem_we_o, cpu_hold_o, done_o, error_o;
  logic [7:0]  imem_addr_o;
  logic [19:0] imem_wdata_o;
  int          pass = 0, total = 0;
  typedef struct packed {
    logic        st;
    logic        v;
    logic [7:0]  d;
    logic [32:0] e;
  } vec_t;
  vec_t tbl[$];
  wire [32:0] outs = {in_ready_o, imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o, done_o, error_o};
  localparam logic [32:0] RST_OUT = {1'b0, 1'b0, 8'h00, 20'h0, 1'b1, 1'b0, 1'b0};
  imem_program_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .cpu_hold_o(cpu_hold_o), .done_o(done_o), .error_o(error_o)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [32:0] got, input logic [32:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s got={rdy,we,addr,wdata,hold,done,err}=%h exp=%h", nm, got, exp);
  endtask
  task automatic add(input logic st, input logic v, input logic [7:0] d, input logic rdy, input logic we,
                     input logic [7:0] a, input logic [19:0] w, input logic h, input logic dn, input logic er);
    vec_t t;
    t.st = st;
    t.v  = v;
    t.d  = d;
    t.e  = {rdy, we, a, w, h, dn, er};
    tbl.push_back(t);
  endtask
  task automatic drive(input logic st, input logic v, input logic [7:0] d);
    start_i    = st;
    in_valid_i = v;
    in_data_i  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input vec_t t, input string nm);
    drive(t.st, t.v, t.d);
    chk(nm, outs, t.e);
  endtask
  initial begin
    logic [19:0] prev_wd, wk;
    logic [7:0]  b0, b1, b2, cs;
    logic        we_seen;
    int          got;
    vec_t        t;
    // two-word program with a stall, an ignored start and a byte offered while not ready
    add(1,0,8'h00, 1,0,8'd0,20'h00000,1,0,0);
    add(0,1,8'h02, 1,0,8'd0,20'h00000,1,0,0);
    add(0,1,8'h00, 1,0,8'd0,20'h00000,1,0,0);
    add(0,1,8'h34, 1,0,8'd0,20'h00000,1,0,0);
    add(0,0,8'h00, 1,0,8'd0,20'h00000,1,0,0);
    add(1,1,8'h12, 1,0,8'd0,20'h00000,1,0,0);
    add(0,1,8'h05, 0,1,8'd0,20'h51234,1,0,0);
    add(0,1,8'hFF, 1,0,8'd1,20'h51234,1,0,0);
    add(0,1,8'hCD, 1,0,8'd1,20'h51234,1,0,0);
    add(0,0,8'h00, 1,0,8'd1,20'h51234,1,0,0);
    add(0,1,8'hAB, 1,0,8'd1,20'h51234,1,0,0);
    add(0,1,8'h0F, 0,1,8'd1,20'hFABCD,1,0,0);
`ifdef LOADER_CHECKSUM_EN
    add(0,0,8'h00, 1,0,8'd2,20'hFABCD,1,0,0);
    add(0,1,8'h4A, 0,0,8'd2,20'hFABCD,0,1,0);
`else
    add(0,0,8'h00, 0,0,8'd2,20'hFABCD,0,1,0);
`endif
    add(0,1,8'h77, 0,0,8'd2,20'hFABCD,0,1,0);
    // N = 0 goes straight to done
    add(1,0,8'h00, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h00, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h00, 0,0,8'd0,20'hFABCD,0,1,0);
    // N = 257 exceeds capacity
    add(1,0,8'h00, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h01, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h01, 0,0,8'd0,20'hFABCD,1,0,1);
    add(0,1,8'h55, 0,0,8'd0,20'hFABCD,1,0,1);
    // malformed b2 aborts, then a valid session recovers
    add(1,0,8'h00, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h01, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h00, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h34, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h12, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h15, 0,0,8'd0,20'hFABCD,1,0,1);
    add(1,0,8'h00, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h01, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h00, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h78, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h56, 1,0,8'd0,20'hFABCD,1,0,0);
    add(0,1,8'h03, 0,1,8'd0,20'h35678,1,0,0);
`ifdef LOADER_CHECKSUM_EN
    add(0,0,8'h00, 1,0,8'd1,20'h35678,1,0,0);
    add(0,1,8'h2D, 0,0,8'd1,20'h35678,0,1,0);
    // wrong checksum
    add(1,0,8'h00, 1,0,8'd0,20'h35678,1,0,0);
    add(0,1,8'h01, 1,0,8'd0,20'h35678,1,0,0);
    add(0,1,8'h00, 1,0,8'd0,20'h35678,1,0,0);
    add(0,1,8'h34, 1,0,8'd0,20'h35678,1,0,0);
    add(0,1,8'h12, 1,0,8'd0,20'h35678,1,0,0);
    add(0,1,8'h05, 0,1,8'd0,20'h51234,1,0,0);
    add(0,0,8'h00, 1,0,8'd1,20'h51234,1,0,0);
    add(0,1,8'h24, 0,0,8'd1,20'h51234,1,0,1);
    prev_wd = 20'h51234;
`else
    add(0,0,8'h00, 0,0,8'd1,20'h35678,0,1,0);
    prev_wd = 20'h35678;
`endif
    #12;
    chk("reset", outs, RST_OUT);
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));
    // full-capacity load: N = 256, last write at 0xFF, address wraps to 0
    t = '0;
    t.st = 1'b1;
    t.e = {1'b1, 1'b0, 8'd0, prev_wd, 1'b1, 1'b0, 1'b0};
    run(t, "cap_start");
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h01);
    cs = '0;
    for (int k = 0; k < 256; k++) begin
      b0 = 8'(k);
      b1 = ~b0;
      b2 = {4'h0, b0[3:0]};
      wk = {b2[3:0], b1, b0};
      cs = cs ^ b0 ^ b1 ^ b2;
      drive(0, 1, b0);
      drive(0, 1, b1);
      drive(0, 1, b2);
      chk($sformatf("cap_wr%0d", k), outs, {1'b0, 1'b1, b0, wk, 1'b1, 1'b0, 1'b0});
      drive(0, 0, 8'h00);
    end
`ifdef LOADER_CHECKSUM_EN
    drive(0, 1, cs);
`endif
    chk("cap_done", outs, {1'b0, 1'b0, 8'd0, wk, 1'b0, 1'b1, 1'b0});
    // reset mid-word with a ragged in_valid
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h01);
    drive(0, 1, 8'h00);
    got = 0;
    we_seen = 1'b0;
    for (int c = 0; c < 60 && got < 2; c++) begin
      in_valid_i = 1'(($urandom_range(0, 1)));
      in_data_i = got == 0 ? 8'h11 : 8'h22;
      if (in_valid_i) got++;
      @(posedge clk);
      #1;
      we_seen |= imem_we_o;
    end
    in_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", outs, RST_OUT);
    chk("rst_no_we", {32'd0, we_seen}, 33'd0);
    @(posedge clk);
    #1;
    chk("rst_held", outs, RST_OUT);
    #2;
    rst_n = 1'b1;
    drive(0, 1, 8'h55);
    chk("rst_idle", outs, RST_OUT);
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h01);
    drive(0, 1, 8'h00);
    drive(0, 1, 8'h9A);
    drive(0, 1, 8'hBC);
    drive(0, 1, 8'h0E);
    chk("rst_recover_wr", outs, {1'b0, 1'b1, 8'd0, 20'hEBC9A, 1'b1, 1'b0, 1'b0});
    drive(0, 0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    drive(0, 1, 8'h28);
`endif
    chk("rst_recover_done", outs, {1'b0, 1'b0, 8'd1, 20'hEBC9A, 1'b0, 1'b1, 1'b0});
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Write-side companion to the CPU's instruction fetch path.
- Accepts a byte stream over a valid/ready handshake, packs each group of three bytes into one 20-bit instruction word, and writes the words into instruction memory at consecutive addresses.
- Holds the CPU in reset (cpu_hold) from power-up until a complete, well-formed program has been written.

Parameters:
- ADDR_W, 8, instruction memory address width; capacity is 2^ADDR_W words.
- INSTR_W, 20, instruction word width; fixed at 20 and packed from 3 bytes, with upper 4 bits of byte 2 required to be zero.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle; a byte transfers when in_valid and in_ready are both high on a rising edge.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  INSTR_W  write data.
- cpu_hold  output  1  high keeps the CPU in reset.
- done  output  1  program loaded, CPU released.
- error  output  1  session aborted by a protocol error.

Behaviour:
- Reset values (async, rst_n=0):
  - State S_IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, done=0, error=0, internal count/byte index/checksum = 0.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×3 payload bytes (b0=instr[7:0], b1=instr[15:8], b2=instr[19:16] in low nibble).
- States and transitions:
  - S_IDLE: in_ready=0. start -> S_LEN0, clear imem_addr, error, done, byte index; set cpu_hold=1.
  - S_LEN0: in_ready=1. On transfer, latch N[7:0] -> S_LEN1.
  - S_LEN1: in_ready=1. On transfer, latch N[15:8], then decide:
    - N==0 -> S_DONE.
    - N > 2^ADDR_W -> S_ERR.
    - otherwise -> S_DATA.
  - S_DATA: in_ready=1. Byte index cycles 0,1,2; bytes shift into a 20-bit assembly register. Third byte accepted -> S_WRITE. If b2[7:4]≠0 -> S_ERR, no write.
  - S_WRITE: in_ready=0. imem_we=1 for exactly this cycle with imem_addr/imem_wdata stable. Next cycle: imem_addr+1, words written +1; if written==N -> S_DONE (or S_CSUM with feature), else S_DATA.
  - S_DONE: done=1, cpu_hold=0, in_ready=0. start -> S_LEN0 (reload; cpu_hold reasserts the same cycle done drops).
  - S_ERR: error=1, cpu_hold=1, in_ready=0. Only start or reset leaves; start -> S_LEN0.
- Latency: imem_we asserts the cycle after the third byte's transfer edge. Peak throughput is 3 bytes per 4 cycles.
- start while in S_LEN0..S_WRITE is ignored.
- in_valid low mid-word: wait indefinitely, partial word retained, no timeout.
- N==2^ADDR_W: last write at address 2^ADDR_W−1; imem_addr then wraps to 0 but no further write occurs.
- Reset mid-session: immediate return to reset values; partially loaded memory contents are not cleared.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: after the last word, state S_CSUM (in_ready=1) accepts one byte.
  - It must equal the XOR of all payload bytes (length bytes excluded).
  - Match -> S_DONE. Mismatch -> S_ERR.
  - The checksum accumulator clears on start.
- Undefined: S_CSUM does not exist; S_WRITE on the last word goes directly to S_DONE.

Test Plan:
- Reset then start, stream 02 00 | 34 12 05 | CD AB 0F -> imem_we pulses at addr 0 data 0x51234, addr 1 data 0xFABCD; done=1, cpu_hold=0 one cycle after second write.
- start, stream 00 00 -> S_DONE directly, no imem_we, done=1.
- ADDR_W=8, stream length 01 01 (N=257) -> error=1, cpu_hold=1, in_ready=0, no writes.
- Payload byte b2=0x15 in word 0 -> error=1, no write at addr 0; subsequent start with valid stream recovers to done=1.
- in_valid toggled randomly and rst_n pulsed low mid-word -> outputs return to reset values at once; no spurious imem_we.
- With LOADER_CHECKSUM_EN: N=1, bytes 34 12 05, checksum 0x23 -> done=1; checksum 0x24 -> error=1, cpu_hold=1.
